imem_responder: RTL and testbench

Instruction-memory responder for the RiSC16 core: the memory-side end of the instruction fetch interface. It accepts byte-addressed fetch requests from the fetch stage and returns a 16-bit instruction after a configurable number of wait states. It flags misaligned and out-of-range addresses. A byte-serial load port lets a host write the program image between fetches.

---
 rtl/imem_responder_if.sv | 27 ++
 rtl/imem_responder.sv | 143 ++++++++++++++
 tb/tb_imem_responder.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch and program-load signals between the RiSC16 fetch stage / loader host
// (master) and the instruction-memory responder (slave).
interface imem_responder_if #(
    parameter int DEPTH_LOG2 = 8
);
    logic                  fetch_req;
    logic [15:0]           fetch_addr;
    logic                  fetch_valid;
    logic [15:0]           fetch_instr;
    logic                  fetch_err;
    logic                  load_start;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_ready;
    logic [DEPTH_LOG2-1:0] load_words;
    logic                  busy;

    modport master (
        output fetch_req, fetch_addr, load_start, load_valid, load_byte,
        input  fetch_valid, fetch_instr, fetch_err, load_ready, load_words, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_valid, load_byte,
        output fetch_valid, fetch_instr, fetch_err, load_ready, load_words, busy
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: byte-addressed fetches answered after a fixed
// number of wait states, plus a byte-serial port for loading the program image.
//
// state  | meaning
// IDLE   | ready for a fetch; load bytes accepted here only
// WAIT   | counting down wait states for an accepted, well-formed fetch
// RESP   | fetch_valid high for one cycle with instruction or error
module imem_responder #(
    parameter int WORD_LEN    = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input logic             clk,
    input logic             reset,
    imem_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic                  err_q, err_d;
    logic [WORD_LEN-1:0]   instr_q, instr_d;
    logic [7:0]            hi_q, hi_d;
    logic                  hi_pending_q, hi_pending_d;
    logic [DEPTH_LOG2-1:0] load_ptr_q, load_ptr_d;
    logic [WORD_LEN-1:0]   mem [DEPTH];

    logic                  req_err;
    logic                  load_ready;
    logic                  load_accept;
    logic                  mem_we;

    assign req_err = bus.fetch_addr[0] | ((bus.fetch_addr >> (DEPTH_LOG2 + 1)) != 16'd0);

    // load_start outranks a fetch request in IDLE, so the fetch waits one cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        err_d      = err_q;
        instr_d    = instr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.fetch_req && !bus.load_start) begin
                    addr_d = bus.fetch_addr[DEPTH_LOG2:1];
                    err_d  = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                        instr_d = '0;
                    end else if (WAIT_INIT == 4'd0) begin
                        state_d = S_RESP;
                        instr_d = mem[bus.fetch_addr[DEPTH_LOG2:1]];
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    instr_d = mem[addr_q];
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            instr_q    <= instr_d;
        end
    end

    assign load_ready  = (state_q == S_IDLE) && !bus.fetch_req && !bus.load_start;
    assign load_accept = bus.load_valid && load_ready;

    always_comb begin
        hi_d         = hi_q;
        hi_pending_d = hi_pending_q;
        load_ptr_d   = load_ptr_q;
        mem_we       = 1'b0;
        if (bus.load_start) begin
            load_ptr_d   = '0;
            hi_pending_d = 1'b0;
        end else if (load_accept) begin
            if (!hi_pending_q) begin
                hi_d         = bus.load_byte;
                hi_pending_d = 1'b1;
            end else begin
                mem_we       = 1'b1;
                load_ptr_d   = load_ptr_q + DEPTH_LOG2'(1);
                hi_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q         <= 8'd0;
            hi_pending_q <= 1'b0;
            load_ptr_q   <= '0;
        end else begin
            hi_q         <= hi_d;
            hi_pending_q <= hi_pending_d;
            load_ptr_q   <= load_ptr_d;
        end
    end

    // Program image survives reset; only the load port writes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_ptr_q] <= {hi_q, bus.load_byte};
        end
    end

    assign bus.fetch_valid = (state_q == S_RESP);
    assign bus.fetch_err   = (state_q == S_RESP) && err_q;
    assign bus.fetch_instr = instr_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.load_ready  = load_ready;
    assign bus.load_words  = load_ptr_q;
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table-driven fetches, multi-cycle
// corner sequences and a randomized load/fetch mix against a behavioural model.
module tb_imem_responder;
    localparam int WS = 2;
    localparam int DL = 8;
    localparam int NW = 1 << DL;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    imem_responder_if #(.DEPTH_LOG2(DL)) bus_if ();

    imem_responder #(
        .WORD_LEN    (16),
        .DEPTH_LOG2  (DL),
        .WAIT_STATES (WS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model of the program image and load port.
    logic [15:0] ref_mem [NW];
    int          ref_ptr = 0;
    logic        ref_hp  = 1'b0;
    logic [7:0]  ref_hi  = 8'd0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!ref_hp) begin
            ref_hi = b;
            ref_hp = 1'b1;
        end else begin
            ref_mem[ref_ptr] = {ref_hi, b};
            ref_ptr = (ref_ptr + 1) % NW;
            ref_hp  = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.load_valid = 1'b1;
        bus_if.load_byte  = b;
        #1;
        chk("load_ready_idle", 32'(bus_if.load_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_if.load_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        bus_if.load_start = 1'b1;
        tick();
        bus_if.load_start = 1'b0;
        ref_ptr = 0;
        ref_hp  = 1'b0;
    endtask

    task automatic fetch_chk(input logic [15:0] a, input logic [15:0] ei, input logic ee,
                             input int el, input string nm);
        int n;
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = a;
        tick();
        bus_if.fetch_req = 1'b0;
        chk({nm, "_busy"}, 32'(bus_if.busy), 32'd1);
        n = 1;
        while (!bus_if.fetch_valid && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(el));
        chk({nm, "_instr"}, 32'(bus_if.fetch_instr), 32'(ei));
        chk({nm, "_err"}, 32'(bus_if.fetch_err), 32'(ee));
        tick();
        chk({nm, "_valid_drop"}, 32'(bus_if.fetch_valid), 32'd0);
        chk({nm, "_hold"}, 32'(bus_if.fetch_instr), 32'(ei));
        chk({nm, "_err_drop"}, 32'(bus_if.fetch_err), 32'd0);
        chk({nm, "_busy_drop"}, 32'(bus_if.busy), 32'd0);
    endtask

    // Expected response straight from the addressing rules.
    task automatic fetch_model(input logic [15:0] a, input string nm);
        logic        e_err;
        logic [15:0] e_instr;
        e_err   = (int'(a) % 2 != 0) || (int'(a) >= 2 * NW);
        e_instr = e_err ? 16'h0000 : ref_mem[int'(a) / 2];
        fetch_chk(a, e_instr, e_err, e_err ? 1 : WS + 1, nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t [3];
        int nv;
        logic [15:0] a;

        bus_if.fetch_req  = 1'b0;
        bus_if.fetch_addr = 16'h0000;
        bus_if.load_start = 1'b0;
        bus_if.load_valid = 1'b0;
        bus_if.load_byte  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", 32'(bus_if.fetch_valid), 32'd0);
        chk("rst_instr", 32'(bus_if.fetch_instr), 32'd0);
        chk("rst_err", 32'(bus_if.fetch_err), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_words", 32'(bus_if.load_words), 32'd0);
        chk("rst_ready", 32'(bus_if.load_ready), 32'd1);

        // Basic load
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        chk("load_words_2", 32'(bus_if.load_words), 32'd2);

        vecs[0] = '{16'h0002, 16'hABCD, 1'b0, WS + 1};
        vecs[1] = '{16'h0000, 16'h1234, 1'b0, WS + 1};
        vecs[2] = '{16'h0003, 16'h0000, 1'b1, 1};
        vecs[3] = '{16'h0200, 16'h0000, 1'b1, 1};
        vecs[4] = '{16'h8000, 16'h0000, 1'b1, 1};
        vecs[5] = '{16'h01FF, 16'h0000, 1'b1, 1};
        vecs[6] = '{16'h01FE, 16'h0000, 1'b0, WS + 1};
        ref_mem[255] = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            fetch_chk(vecs[i].addr, vecs[i].instr, vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Back-to-back fetches with fetch_req held high
        send_word(16'h5A5A);
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus_if.fetch_valid && n < 40);
            t[k] = cyc;
            if (k == 0) chk("b2b_first_lat", 32'(n), 32'(WS + 1));
            chk($sformatf("b2b_instr%0d", k), 32'(bus_if.fetch_instr), 32'(ref_mem[k]));
            bus_if.fetch_addr = 16'(2 * (k + 1));
        end
        bus_if.fetch_req = 1'b0;
        chk("b2b_gap01", 32'(t[1] - t[0]), 32'(WS + 2));
        chk("b2b_gap12", 32'(t[2] - t[1]), 32'(WS + 2));
        tick();

        // Fetch and load byte presented together
        chk("cont_words_pre", 32'(bus_if.load_words), 32'd3);
        bus_if.load_valid = 1'b1;
        bus_if.load_byte  = 8'h77;
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = 16'h0000;
        #1;
        chk("cont_ready_req", 32'(bus_if.load_ready), 32'd0);
        tick();
        bus_if.fetch_req = 1'b0;
        chk("cont_ready_wait", 32'(bus_if.load_ready), 32'd0);
        n = 1;
        while (!bus_if.fetch_valid && n < 40) begin
            tick();
            n++;
        end
        chk("cont_lat", 32'(n), 32'(WS + 1));
        chk("cont_instr", 32'(bus_if.fetch_instr), 32'h1234);
        chk("cont_ready_resp", 32'(bus_if.load_ready), 32'd0);
        tick();
        chk("cont_ready_idle", 32'(bus_if.load_ready), 32'd1);
        tick();
        bus_if.load_valid = 1'b0;
        model_byte(8'h77);
        chk("cont_words_hi", 32'(bus_if.load_words), 32'd3);
        send_byte(8'h88);
        chk("cont_words_post", 32'(bus_if.load_words), 32'd4);
        fetch_chk(16'h0006, 16'h7788, 1'b0, WS + 1, "write_then_fetch");

        // load_start together with a load byte: byte dropped
        bus_if.load_start = 1'b1;
        bus_if.load_valid = 1'b1;
        bus_if.load_byte  = 8'h99;
        #1;
        chk("start_ready", 32'(bus_if.load_ready), 32'd0);
        tick();
        bus_if.load_start = 1'b0;
        bus_if.load_valid = 1'b0;
        ref_ptr = 0;
        ref_hp  = 1'b0;
        chk("start_words", 32'(bus_if.load_words), 32'd0);
        send_byte(8'hDE);
        send_byte(8'hAD);
        chk("start_words_1", 32'(bus_if.load_words), 32'd1);
        fetch_chk(16'h0000, 16'hDEAD, 1'b0, WS + 1, "start_drop");

        // Odd byte count then resync
        send_byte(8'h11);
        pulse_start();
        send_byte(8'h22);
        send_byte(8'h33);
        fetch_chk(16'h0000, 16'h2233, 1'b0, WS + 1, "resync");
        chk("resync_words", 32'(bus_if.load_words), 32'd1);

        // Load 257 words: pointer wraps, word 0 overwritten
        pulse_start();
        for (int i = 0; i <= NW; i++) begin
            send_word((i == NW) ? 16'hBEEF : 16'(i * 37 + 'h1000));
        end
        chk("wrap_words", 32'(bus_if.load_words), 32'd1);
        fetch_chk(16'h0000, 16'hBEEF, 1'b0, WS + 1, "wrap_word0");
        fetch_chk(16'h0002, 16'h1025, 1'b0, WS + 1, "wrap_word1");

        // Randomized mix against the model
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 3) begin
                send_word(16'($urandom));
                chk("rnd_words", 32'(bus_if.load_words), 32'(ref_ptr));
            end else if (op == 3) begin
                pulse_start();
                chk("rnd_start_words", 32'(bus_if.load_words), 32'd0);
            end else if (op == 4) begin
                send_byte(8'($urandom));
            end else begin
                case ($urandom_range(0, 3))
                    0, 1:    a = 16'($urandom_range(0, NW - 1) * 2);
                    2:       a = 16'($urandom_range(0, NW - 1) * 2 + 1);
                    default: a = 16'($urandom);
                endcase
                fetch_model(a, $sformatf("rnd%0d", i));
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset while a fetch is in WAIT
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = 16'h0002;
        tick();
        bus_if.fetch_req = 1'b0;
        chk("rstw_busy_pre", 32'(bus_if.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_ptr = 0;
        ref_hp  = 1'b0;
        chk("rstw_busy", 32'(bus_if.busy), 32'd0);
        chk("rstw_instr", 32'(bus_if.fetch_instr), 32'd0);
        chk("rstw_valid", 32'(bus_if.fetch_valid), 32'd0);
        chk("rstw_words", 32'(bus_if.load_words), 32'd0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.fetch_valid) nv++;
        end
        chk("rstw_no_valid", 32'(nv), 32'd0);
        fetch_model(16'h0002, "rstw_retained1");
        fetch_model(16'h0000, "rstw_retained0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
